// File: rtl/pulser_pkg.sv
// Shared types and constants for the delay pulse sequencer.
package pulser_pkg;

  localparam int unsigned N_CH               = 8;
  localparam int unsigned DLY_W              = 16;
  localparam int unsigned PULSE_BITS_DEFAULT = 32;
  // One extra bit so delay + pulse length never wraps.
  localparam int unsigned CNT_W              = DLY_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/pulse_lane.sv
// One transmit lane: window compare against the shared burst time and
// MSB-first selection of the pulse shape bit, registered onto the pin.
module pulse_lane
  import pulser_pkg::*;
#(
  parameter int unsigned PULSE_BITS = PULSE_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [CNT_W-1:0]      t,
  input  logic [DLY_W-1:0]      d_n,
  input  logic                  sel_n,
  input  logic [PULSE_BITS-1:0] shape,
  output logic                  tx
);

  localparam int unsigned      IdxW     = $clog2(PULSE_BITS);
  localparam logic [CNT_W-1:0] PulseLen = CNT_W'(PULSE_BITS);

  logic [CNT_W-1:0] d_ext;
  logic [CNT_W-1:0] offs;
  logic [IdxW-1:0]  idx;
  logic             in_win;
  logic             tx_d;

  // Window check and bit select; idx is only meaningful inside the window.
  always_comb begin
    d_ext  = {1'b0, d_n};
    offs   = t - d_ext;
    idx    = IdxW'(PulseLen - CNT_W'(1) - offs);
    in_win = (t >= d_ext) && (t < d_ext + PulseLen);
    tx_d   = 1'b0;
    if (run && sel_n && in_win) begin
      tx_d = shape[idx];
    end
  end

  // Output register; anything outside RUN drives the pin low.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b0;
    end else begin
      tx <= tx_d;
    end
  end

endmodule

// File: rtl/delay_pulse_sequencer.sv
// Transmit burst sequencer: on fire, latches the channel configuration and
// shifts the pulse shape out of every enabled channel after its own delay.
// Optional build macro PULSER_ABORT_EN adds an abort input that cancels an
// armed or running burst without a done pulse.
module delay_pulse_sequencer
  import pulser_pkg::*;
#(
  parameter int unsigned PULSE_BITS = PULSE_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PULSER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  fire,
  input  logic                  cfg_busy,
  input  logic [N_CH-1:0]       channel_select,
  input  logic [PULSE_BITS-1:0] pulse_shape,
  input  logic [DLY_W-1:0]      ch0delay,
  input  logic [DLY_W-1:0]      ch1delay,
  input  logic [DLY_W-1:0]      ch2delay,
  input  logic [DLY_W-1:0]      ch3delay,
  input  logic [DLY_W-1:0]      ch4delay,
  input  logic [DLY_W-1:0]      ch5delay,
  input  logic [DLY_W-1:0]      ch6delay,
  input  logic [DLY_W-1:0]      ch7delay,
  output logic [N_CH-1:0]       tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] PulseLen = CNT_W'(PULSE_BITS);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      t_q, t_d;
  logic [CNT_W-1:0]      end_q, end_d;
  logic [N_CH-1:0]       sel_q;
  logic [PULSE_BITS-1:0] shape_q;
  logic [DLY_W-1:0]      dly_in [N_CH];
  logic [DLY_W-1:0]      dly_q  [N_CH];
  logic [DLY_W-1:0]      max_dly;
  logic                  load;
  logic                  run;
  logic                  busy_d;
  logic                  done_d;

  // Gather the per-channel delay ports into an array.
  always_comb begin
    dly_in[0] = ch0delay;
    dly_in[1] = ch1delay;
    dly_in[2] = ch2delay;
    dly_in[3] = ch3delay;
    dly_in[4] = ch4delay;
    dly_in[5] = ch5delay;
    dly_in[6] = ch6delay;
    dly_in[7] = ch7delay;
  end

  // Largest delay among the latched, selected channels (0 for an empty mask).
  always_comb begin
    max_dly = '0;
    for (int unsigned n = 0; n < N_CH; n++) begin
      if (sel_q[n] && (dly_q[n] > max_dly)) begin
        max_dly = dly_q[n];
      end
    end
  end

  // Next-state, counter and status logic.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    end_d   = end_q;
    busy_d  = busy;
    done_d  = 1'b0;
    load    = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fire && !cfg_busy) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = StArm;
        end
      end
      StArm: begin
        end_d   = {1'b0, max_dly} + PulseLen;
        t_d     = '0;
        state_d = StRun;
      end
      StRun: begin
        run = 1'b1;
        t_d = t_q + CNT_W'(1);
        if (t_q == end_q - CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef PULSER_ABORT_EN
    // Abort only bites while a burst is armed or running.
    if (abort && ((state_q == StArm) || (state_q == StRun))) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      run     = 1'b0;
    end
`endif
  end

  // State, counters, status outputs and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      end_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sel_q   <= '0;
      shape_q <= '0;
      for (int unsigned n = 0; n < N_CH; n++) begin
        dly_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      end_q   <= end_d;
      busy    <= busy_d;
      done    <= done_d;
      if (load) begin
        sel_q   <= channel_select;
        shape_q <= pulse_shape;
        for (int unsigned n = 0; n < N_CH; n++) begin
          dly_q[n] <= dly_in[n];
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : gen_lane
    pulse_lane #(
      .PULSE_BITS(PULSE_BITS)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .t    (t_q),
      .d_n  (dly_q[g]),
      .sel_n(sel_q[g]),
      .shape(shape_q),
      .tx   (tx_out[g])
    );
  end

endmodule

// File: tb/tb_delay_pulse_sequencer.sv
// Self-checking bench for delay_pulse_sequencer against a cycle-indexed
// burst model (expected outputs as a function of clocks since fire).
module tb_delay_pulse_sequencer;

  localparam int P = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         fire;
  logic         cfg_busy;
  logic [7:0]   channel_select;
  logic [P-1:0] pulse_shape;
  logic [15:0]  dly [8];
  logic [7:0]   tx_out;
  logic         busy;
  logic         done;
`ifdef PULSER_ABORT_EN
  logic         abort;
`endif

  int errors = 0;
  int checks = 0;

  // Latched copy of the burst configuration used by the model.
  logic [7:0]   m_sel;
  logic [P-1:0] m_shape;
  int           m_dly [8];
  int           m_end;

  always #5 clk = ~clk;

  delay_pulse_sequencer #(
    .PULSE_BITS(P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef PULSER_ABORT_EN
    .abort         (abort),
`endif
    .fire          (fire),
    .cfg_busy      (cfg_busy),
    .channel_select(channel_select),
    .pulse_shape   (pulse_shape),
    .ch0delay      (dly[0]),
    .ch1delay      (dly[1]),
    .ch2delay      (dly[2]),
    .ch3delay      (dly[3]),
    .ch4delay      (dly[4]),
    .ch5delay      (dly[5]),
    .ch6delay      (dly[6]),
    .ch7delay      (dly[7]),
    .tx_out        (tx_out),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected pins c clocks after the fire edge: bit k of the burst for a
  // channel with delay d appears c = d + k + 2 edges after fire.
  function automatic logic [7:0] model_tx(input int c);
    logic [7:0] r;
    int k;
    r = '0;
    k = c - 2;
    for (int n = 0; n < 8; n++) begin
      if (m_sel[n] && k >= m_dly[n] && k < m_dly[n] + P) begin
        r[n] = m_shape[P-1-(k-m_dly[n])];
      end
    end
    return r;
  endfunction

  task automatic latch_model();
    int mx;
    mx      = 0;
    m_sel   = channel_select;
    m_shape = pulse_shape;
    for (int n = 0; n < 8; n++) begin
      m_dly[n] = int'(dly[n]);
      if (channel_select[n] && m_dly[n] > mx) mx = m_dly[n];
    end
    m_end = mx + P;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " tx"}, 32'(tx_out), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Fire one burst from a negedge and check every cycle until idle again.
  task automatic burst(input string name, input bit scramble, input bit refire,
                       input int rst_at, input int abort_at);
    int kill;
    bit dead;
    kill = -1;
    latch_model();
    fire     = 1'b1;
    cfg_busy = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= m_end + 3; c++) begin
      @(negedge clk);
      dead = (kill >= 0) && (c >= kill);
      chk($sformatf("%s c=%0d tx", name, c), 32'(tx_out), dead ? 32'd0 : 32'(model_tx(c)));
      chk($sformatf("%s c=%0d busy", name, c), 32'(busy),
          32'(!dead && c <= m_end + 1));
      chk($sformatf("%s c=%0d done", name, c), 32'(done),
          32'(!dead && c == m_end + 2));
      fire = (refire && c >= 3 && c <= 8) || (c == abort_at);
      rst  = (c == rst_at);
      if (c == rst_at || c == abort_at) kill = c + 1;
`ifdef PULSER_ABORT_EN
      abort = (c == abort_at);
`endif
      if (scramble) begin
        channel_select = 8'($urandom);
        pulse_shape    = $urandom;
        cfg_busy       = 1'($urandom);
        for (int n = 0; n < 8; n++) dly[n] = 16'($urandom);
      end
    end
    cfg_busy = 1'b0;
  endtask

  task automatic set_delays(input int step);
    for (int n = 0; n < 8; n++) dly[n] = 16'(n * step);
  endtask

  initial begin
    rst            = 1'b1;
    fire           = 1'b0;
    cfg_busy       = 1'b0;
    channel_select = '0;
    pulse_shape    = '0;
    set_delays(0);
`ifdef PULSER_ABORT_EN
    abort          = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    channel_select = 8'h01;
    pulse_shape    = 32'hA5A5_0001;
    burst("single", 1'b0, 1'b0, -1, -1);

    channel_select = 8'hFF;
    pulse_shape    = 32'h8000_0000;
    set_delays(3);
    burst("stagger", 1'b0, 1'b0, -1, -1);

    // fire while configuration is busy must not start anything
    channel_select = 8'hFF;
    pulse_shape    = 32'hFFFF_FFFF;
    set_delays(0);
    fire     = 1'b1;
    cfg_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("cfgbusy%0d", i));
    end
    fire     = 1'b0;
    cfg_busy = 1'b0;
    @(negedge clk);
    check_idle("cfgbusy_release");

    channel_select = 8'h0F;
    burst("refire", 1'b0, 1'b1, -1, -1);

    channel_select = 8'hFF;
    pulse_shape    = 32'hFFFF_FFFF;
    set_delays(0);
    burst("rst_mid", 1'b0, 1'b0, 11, -1);
    channel_select = 8'hFF;
    pulse_shape    = 32'hFFFF_FFFF;
    set_delays(0);
    burst("after_rst", 1'b0, 1'b0, -1, -1);

`ifdef PULSER_ABORT_EN
    channel_select = 8'hFF;
    pulse_shape    = 32'hFFFF_FFFF;
    set_delays(0);
    burst("abort", 1'b0, 1'b0, -1, 6);
    @(negedge clk);
    check_idle("post_abort");
`endif

    for (int r = 0; r < 6; r++) begin
      channel_select = 8'($urandom);
      pulse_shape    = $urandom;
      for (int n = 0; n < 8; n++) dly[n] = 16'($urandom_range(0, 40));
      burst($sformatf("rand%0d", r), 1'b1, 1'($urandom), -1, -1);
    end

    channel_select = 8'h80;
    pulse_shape    = 32'h0000_0001;
    set_delays(0);
    dly[7]         = 16'hFFFF;
    burst("maxdly", 1'b0, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
